// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq -- multi-cycle multiply/divide unit with HI/LO registers for the
// execute stage. Operands and results are computed in the accept cycle and
// held in a pending {HI,LO} pair. That pair is committed to hi/lo when the
// latency counter runs out.
//
// Parameters:
//   WIDTH       operand and HI/LO width (>= 8)
//   MUL_CYCLES  busy cycles for mult/multu/madd/maddu/msub/msubu (>= 1)
//   DIV_CYCLES  busy cycles for div/divu (>= 1)
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   start   in   E-stage instruction is an MD op
//   op      in   4-bit operation code (see OP_* below)
//   D1, D2  in   forwarded rs / rt values
//   cancel  in   E-stage instruction is flushed this cycle
//   busy    out  an operation is in flight (registered)
//   hi, lo  out  HI / LO registers
//
// Configuration macro:
//   MD_MADD_EN  when defined, op codes 7..10 (madd/maddu/msub/msubu) are
//               implemented. When undefined, they behave as no-ops and the
//               accumulate adder is not built.
// -----------------------------------------------------------------------------
module muldiv_seq #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

    logic               busy_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   pend_hi_r;
    logic [WIDTH-1:0]   pend_lo_r;

    logic               mul_signed_s;
    logic [2*WIDTH-1:0] mul_a_s;
    logic [2*WIDTH-1:0] mul_b_s;
    logic [2*WIDTH-1:0] prod_s;
    logic               neg_a_s;
    logic               neg_b_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH-1:0]   uquo_s;
    logic [WIDTH-1:0]   urem_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    // Operand conditioning, shared multiplier and sign-magnitude divider.
    always_comb begin
        mul_signed_s = 1'b0;
        mul_a_s      = {(2*WIDTH){1'b0}};
        mul_b_s      = {(2*WIDTH){1'b0}};
        neg_a_s      = 1'b0;
        neg_b_s      = 1'b0;
        uquo_s       = ZERO_W;
        urem_s       = ZERO_W;
        quo_s        = ZERO_W;
        rem_s        = ZERO_W;

        case (op)
            OP_MULT, OP_MADD, OP_MSUB: mul_signed_s = 1'b1;
            default:                   mul_signed_s = 1'b0;
        endcase

        // Extending both operands to 2*WIDTH gives the exact product modulo
        // 2^(2*WIDTH) for signed and unsigned operands alike.
        if (mul_signed_s) begin
            mul_a_s = {{WIDTH{D1[WIDTH-1]}}, D1};
            mul_b_s = {{WIDTH{D2[WIDTH-1]}}, D2};
        end else begin
            mul_a_s = {ZERO_W, D1};
            mul_b_s = {ZERO_W, D2};
        end
        prod_s = mul_a_s * mul_b_s;

        neg_a_s = (op == OP_DIV) & D1[WIDTH-1];
        neg_b_s = (op == OP_DIV) & D2[WIDTH-1];
        mag_a_s = neg_a_s ? -D1 : D1;
        mag_b_s = neg_b_s ? -D2 : D2;

        // MIN / -1 needs no special case here. |MIN| / 1 = 2^(WIDTH-1), and
        // negating that wraps back to MIN with a remainder of 0.
        if (D2 == ZERO_W) begin
            quo_s = ONES_W;
            rem_s = D1;
        end else begin
            uquo_s = mag_a_s / mag_b_s;
            urem_s = mag_a_s % mag_b_s;
            quo_s  = (neg_a_s ^ neg_b_s) ? -uquo_s : uquo_s;
            rem_s  = neg_a_s ? -urem_s : urem_s;
        end
    end

    // Control and HI/LO state: accept, count down, commit on the 1->0 edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r    <= 1'b0;
            cnt_r     <= CNT_ZERO;
            hi_r      <= ZERO_W;
            lo_r      <= ZERO_W;
            pend_hi_r <= ZERO_W;
            pend_lo_r <= ZERO_W;
        end else if (busy_r) begin
            // Cancel and start are ignored here. The in-flight op belongs to
            // an instruction that has already committed.
            if (cnt_r == CNT_ONE) begin
                hi_r   <= pend_hi_r;
                lo_r   <= pend_lo_r;
                busy_r <= 1'b0;
                cnt_r  <= CNT_ZERO;
            end else begin
                cnt_r  <= cnt_r - CNT_ONE;
            end
        end else if (start && !cancel) begin
            case (op)
                OP_MTHI: hi_r <= D1;
                OP_MTLO: lo_r <= D1;
                OP_MULT, OP_MULTU: begin
                    {pend_hi_r, pend_lo_r} <= prod_s;
                    cnt_r  <= CNT_MUL;
                    busy_r <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    pend_hi_r <= rem_s;
                    pend_lo_r <= quo_s;
                    cnt_r     <= CNT_DIV;
                    busy_r    <= 1'b1;
                end
`ifdef MD_MADD_EN
                OP_MADD, OP_MADDU: begin
                    {pend_hi_r, pend_lo_r} <= {hi_r, lo_r} + prod_s;
                    cnt_r  <= CNT_MUL;
                    busy_r <= 1'b1;
                end
                OP_MSUB, OP_MSUBU: begin
                    {pend_hi_r, pend_lo_r} <= {hi_r, lo_r} - prod_s;
                    cnt_r  <= CNT_MUL;
                    busy_r <= 1'b1;
                end
`endif
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end else begin
            busy_r <= 1'b0;
        end
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq -- self-checking bench for muldiv_seq.
// The main instance uses the default parameters. A behavioural model tracks
// its hi/lo/busy, and every falling edge is compared against that model.
// Directed vectors also check hand-computed literals against both the DUT and
// the model. A second instance (WIDTH=16, MUL_CYCLES=1) covers the parameter
// sweep. Expectations for ops 7..10 follow MD_MADD_EN.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] D1;
    logic [31:0] D2;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        start16;
    logic [3:0]  op16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        cancel16;
    logic        busy16;
    logic [15:0] hi16;
    logic [15:0] lo16;

    int n_cmp;
    int n_bad;

    muldiv_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .D1(D1), .D2(D2),
        .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
    );

    muldiv_seq #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(2)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op16), .D1(a16), .D2(b16),
        .cancel(cancel16), .busy(busy16), .hi(hi16), .lo(lo16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (default parameters) ----------------
    // Returns the op latency (0 = immediate) and the resulting {HI,LO}.
    function automatic int model_op(input logic [3:0] o, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] h,
                                    input logic [31:0] l, output logic [63:0] r);
        logic [63:0] hl;
        longint      sp;
        logic [63:0] up;
        int          q;
        int          m;
        hl = {h, l};
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        r  = hl;
        case (o)
            4'd1: begin r = sp; return 5; end
            4'd2: begin r = up; return 5; end
            4'd3: begin
                if (b == 32'd0)
                    r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    r = {32'd0, 32'h8000_0000};
                else begin
                    q = $signed(a) / $signed(b);
                    m = $signed(a) % $signed(b);
                    r = {m, q};
                end
                return 10;
            end
            4'd4: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {a % b, a / b};
                return 10;
            end
            4'd5: begin r = {a, l}; return 0; end
            4'd6: begin r = {h, a}; return 0; end
`ifdef MD_MADD_EN
            4'd7:  begin r = hl + sp; return 5; end
            4'd8:  begin r = hl + up; return 5; end
            4'd9:  begin r = hl - sp; return 5; end
            4'd10: begin r = hl - up; return 5; end
`endif
            default: return 0;
        endcase
    endfunction

    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;

    always @(posedge clk or negedge reset) begin
        logic [63:0] res;
        int          lat;
        if (!reset) begin
            m_hi <= 32'd0; m_lo <= 32'd0; m_left <= 0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (start && !cancel) begin
            lat = model_op(op, D1, D2, m_hi, m_lo, res);
            if (lat == 0) begin
                m_hi <= res[63:32];
                m_lo <= res[31:0];
            end else begin
                p_hi   <= res[63:32];
                p_lo   <= res[31:0];
                m_left <= lat;
            end
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        check("cyc_busy", {63'd0, busy}, {63'd0, (m_left != 0)});
        check("cyc_hi", {32'd0, hi}, {32'd0, m_hi});
        check("cyc_lo", {32'd0, lo}, {32'd0, m_lo});
    end

    // Issue one op. Count the falling edges with busy high, and pulse cancel
    // on busy falling edge number pulse_at (-1 = never).
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input int pulse_at, output int nb);
        @(posedge clk); #2;
        start = 1'b1; op = o; D1 = a; D2 = b; cancel = c;
        @(posedge clk); #2;
        start = 1'b0; op = 4'd0; cancel = 1'b0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) nb++;
            else break;
            cancel = (i == pulse_at);
        end
        cancel = 1'b0;
    endtask

    task automatic expect_hl(input string name, input logic [31:0] eh, input logic [31:0] el);
        check({name, "_hi"}, {32'd0, hi}, {32'd0, eh});
        check({name, "_lo"}, {32'd0, lo}, {32'd0, el});
        check({name, "_model_hi"}, {32'd0, m_hi}, {32'd0, eh});
        check({name, "_model_lo"}, {32'd0, m_lo}, {32'd0, el});
    endtask

    initial begin
        int nb;
        n_cmp = 0; n_bad = 0;
        reset = 1'b0; start = 1'b0; op = 4'd0; D1 = 32'd0; D2 = 32'd0; cancel = 1'b0;
        start16 = 1'b0; op16 = 4'd0; a16 = 16'd0; b16 = 16'd0; cancel16 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        expect_hl("rst", 32'd0, 32'd0);
        #1 reset = 1'b1;

        do_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, -1, nb);
        check("mult_busy_cycles", 64'(nb), 64'd5);
        expect_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        do_op(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, -1, nb);
        check("multu_busy_cycles", 64'(nb), 64'd5);
        expect_hl("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, -1, nb);
        check("div_busy_cycles", 64'(nb), 64'd10);
        expect_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        do_op(4'd4, 32'd7, 32'd0, 1'b0, -1, nb);
        expect_hl("divu_by0", 32'd7, 32'hFFFF_FFFF);

        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, nb);
        expect_hl("div_ovf", 32'd0, 32'h8000_0000);

        do_op(4'd3, 32'd100, 32'hFFFF_FFF9, 1'b0, -1, nb);
        expect_hl("div_pos_neg", 32'd2, 32'hFFFF_FFF2);

        // mthi then mtlo on consecutive edges
        @(posedge clk); #2;
        start = 1'b1; op = 4'd5; D1 = 32'h1234;
        @(posedge clk); #2;
        op = 4'd6; D1 = 32'h5678;
        @(negedge clk);
        check("mthi_hi", {32'd0, hi}, 64'h1234);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #2;
        start = 1'b0; op = 4'd0;
        @(negedge clk);
        expect_hl("mtlo", 32'h1234, 32'h5678);
        check("mtlo_busy", {63'd0, busy}, 64'd0);

        do_op(4'd1, 32'd5, 32'd6, 1'b1, -1, nb);
        check("cancel_start_busy", 64'(nb), 64'd0);
        expect_hl("cancel_start", 32'h1234, 32'h5678);

        do_op(4'd1, 32'd3, 32'd4, 1'b0, 1, nb);
        check("cancel_busy_cycles", 64'(nb), 64'd5);
        expect_hl("cancel_busy", 32'd0, 32'd12);

        // accumulate: {hi,lo} = {0, FFFFFFFF} then maddu 1*1
        do_op(4'd5, 32'd0, 32'd0, 1'b0, -1, nb);
        do_op(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, -1, nb);
        do_op(4'd8, 32'd1, 32'd1, 1'b0, -1, nb);
`ifdef MD_MADD_EN
        check("maddu_busy_cycles", 64'(nb), 64'd5);
        expect_hl("maddu", 32'd1, 32'd0);
        do_op(4'd9, 32'd2, 32'd3, 1'b0, -1, nb);
        expect_hl("msub", 32'd0, 32'hFFFF_FFFA);
`else
        check("maddu_off_busy", 64'(nb), 64'd0);
        expect_hl("maddu_off", 32'd0, 32'hFFFF_FFFF);
`endif

        // reset asserted in busy cycle 3 of a div
        do_op(4'd5, 32'h0000_00AA, 32'd0, 1'b0, -1, nb);
        @(posedge clk); #2;
        start = 1'b1; op = 4'd3; D1 = 32'd100; D2 = 32'd7;
        @(posedge clk); #2;
        start = 1'b0; op = 4'd0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_hi", {32'd0, hi}, 64'd0);
        check("rst_mid_lo", {32'd0, lo}, 64'd0);
        @(negedge clk); #1 reset = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_no_commit_busy", {63'd0, busy}, 64'd0);
        expect_hl("rst_no_commit", 32'd0, 32'd0);

        // WIDTH=16, MUL_CYCLES=1
        @(posedge clk); #2;
        start16 = 1'b1; op16 = 4'd1; a16 = 16'h8000; b16 = 16'd2;
        @(posedge clk); #2;
        start16 = 1'b0; op16 = 4'd0;
        @(negedge clk);
        check("w16_busy1", {63'd0, busy16}, 64'd1);
        @(negedge clk);
        check("w16_busy0", {63'd0, busy16}, 64'd0);
        check("w16_hi", {48'd0, hi16}, 64'hFFFF);
        check("w16_lo", {48'd0, lo16}, 64'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Parametrised multi-cycle multiply/divide unit with HI/LO registers for the execute stage of the pipelined MIPS core. It improves on the fixed 32-bit MD unit in four ways:
- operand width and multiply/divide latencies are parameters;
- it adds multiply-accumulate ops;
- divide-by-zero and signed-overflow results are defined;
- it has an explicit cancel input so a flushed E-stage instruction never starts or writes HI/LO.

Hazard logic stalls D on `start || busy` whenever D holds an HI/LO-using instruction.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width (≥ 8).
- `MUL_CYCLES`, 5, busy cycles for multiply/accumulate ops (≥ 1).
- `DIV_CYCLES`, 10, busy cycles for divide ops (≥ 1).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock, rising edge.
  - `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  E-stage instruction is an MD op; sampled each rising edge.
- `op`  in  4  operation code:
  - 0 none
  - 1 mult
  - 2 multu
  - 3 div
  - 4 divu
  - 5 mthi
  - 6 mtlo
  - 7 madd
  - 8 maddu
  - 9 msub
  - 10 msubu
  - 11–15 none
- `D1`  in  WIDTH  forwarded rs value.
- `D2`  in  WIDTH  forwarded rt value.
- `cancel`  in  1  exception/interrupt taken this cycle; E-stage instruction is flushed.
- `busy`  out  1  an operation is in flight.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- **Reset** (`reset`=0, asynchronous): `hi`=0, `lo`=0, `busy`=0, counter=0, pending result cleared.
- **Accepted start:** `start`=1 && `cancel`=0 && `busy`=0 at a rising edge. Any other `start` is ignored; the stall logic guarantees it does not occur.
- **mthi / mtlo:** `hi` (or `lo`) ← `D1` at that edge. No busy.
- **mult / multu:** 2·WIDTH product of `D1`×`D2`, signed or unsigned. Result is latched into pending {HI,LO}. Counter loads `MUL_CYCLES`.
- **madd / maddu / msub / msubu:** pending {HI,LO} = current {`hi`,`lo`} ± product, modulo 2^(2·WIDTH). Counter loads `MUL_CYCLES`.
- **div / divu:** pending LO = quotient, HI = remainder, truncating toward zero; remainder takes the sign of the dividend. Counter loads `DIV_CYCLES`. Boundary cases:
  - Divisor 0: LO = all-ones, HI = `D1`.
  - Signed MIN / −1: LO = MIN, HI = 0.
- **While busy:** `hi`/`lo` keep their old values. Counter decrements each edge. On the edge where the counter goes 1→0, pending is committed to `hi`/`lo` and `busy` falls.
- **Cancel:**
  - `cancel`=1 together with `start` suppresses the op entirely, including mthi/mtlo.
  - `cancel` while busy has no effect: the in-flight op belongs to an older instruction, which has already committed, and it completes normally.
- **op none** with `start`: no state change.
- **Reset mid-operation:** the op is aborted and all state goes to reset values immediately.

## Timing
- Accepted at edge T0: `busy`=1 from T0 until edge T0+N, where N = latency parameter. So `busy` is high for exactly N cycles.
- At edge T0+N: `hi`/`lo` update and `busy` falls on the same edge.
- A new start is accepted at edge T0+N+1 at the earliest. mfhi/mflo issued then reads the new values.
- mthi/mtlo: visible on `hi`/`lo` one edge after the start.
- `busy` is registered; there is no combinational path from inputs to outputs.

## Configuration
- `MD_MADD_EN`:
  - Defined: op codes 7–10 behave as described above.
  - Undefined: op codes 7–10 are treated as none; no busy, no HI/LO change, and the accumulate datapath is not synthesised.

## Test plan
- Reset, then mult D1=0xFFFFFFFE, D2=3 (WIDTH=32): `busy` high 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. Repeat with multu: `hi`=0x00000002, `lo`=0xFFFFFFFA.
- div D1=−7, D2=2: `busy` high 10 cycles; then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. divu 7/0: `lo`=0xFFFFFFFF, `hi`=7. div 0x80000000/−1: `lo`=0x80000000, `hi`=0.
- mthi 0x1234 then mtlo 0x5678 on consecutive edges: `hi`=0x1234 after first edge, `lo`=0x5678 after second; `busy` stays 0.
- mult with `cancel`=1 on the start edge: `busy` stays 0 and HI/LO unchanged. Then `cancel` pulsed at busy cycle 2 of a mult: result still commits at cycle 5.
- With `MD_MADD_EN`: `hi`=0, `lo`=0xFFFFFFFF, then maddu 1×1 gives `hi`=1, `lo`=0. Without the macro: same stimulus leaves `busy`=0 and HI/LO unchanged.
- Reset asserted at busy cycle 3 of a div: `busy`, `hi`, `lo` go to 0 immediately; no commit afterwards. Parameter sweep WIDTH=16, MUL_CYCLES=1: mult 0x8000×2 gives `hi`=0xFFFF, `lo`=0x0000 after 1 cycle.
